// File: rtl/vga_line_fetch.sv
// vga_line_fetch: ping-pong scanline buffer between a word-per-pixel
// framebuffer and the VGA timing generator, with horizontal doubling.
module vga_line_fetch #(
    parameter int BPP     = 4,
    parameter int WIDTH   = 320,
    parameter int LINES   = 240,
    parameter int HDOUBLE = 2,
    parameter int AW      = 17,
    parameter int BASE    = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             newline,
    input  logic             advance,
    input  logic [7:0]       line,
    output logic [3*BPP-1:0] pixel,
    output logic             mem_req,
    output logic [AW-1:0]    mem_addr,
    input  logic             mem_ack,
    input  logic [3*BPP-1:0] mem_rdata,
    output logic             underrun
);

    localparam int PW = 3 * BPP;
    localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int SW = (HDOUBLE > 1) ? $clog2(HDOUBLE) : 1;

    localparam logic [XW-1:0] XLAST  = XW'(WIDTH - 1);
    localparam logic [SW-1:0] SLAST  = SW'(HDOUBLE - 1);
    localparam logic [8:0]    NLINES = 9'(LINES);
    localparam logic [7:0]    LLAST  = 8'(LINES - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    // First framebuffer word of a source line, wrapped to the address space.
    function automatic logic [AW-1:0] start_addr(input logic [7:0] t);
        logic [31:0] a;
        a = 32'(BASE) + 32'(t) * 32'(WIDTH);
        return AW'(a);
    endfunction

    logic [PW-1:0] buf0 [WIDTH];
    logic [PW-1:0] buf1 [WIDTH];

    state_t        state;
    state_t        state_n;
    logic [XW-1:0] x;
    logic [XW-1:0] x_n;
    logic [AW-1:0] addr_n;
    logic          drain;
    logic          drain_n;
    logic [AW-1:0] rstart;
    logic [AW-1:0] rstart_n;
    logic          ur_n;
    logic          wr_en;
    logic          fill_done;

    logic          fsel;
    logic [8:0]    front_line;
    logic [XW-1:0] rd;
    logic [XW-1:0] rd_inc;
    logic [SW-1:0] sub;

    logic [8:0]    line9;
    logic          in_range;
    logic          swap;
    logic          replay;
    logic [7:0]    tgt_new;

    logic [PW-1:0] front_next;
    logic [PW-1:0] front_first;
    logic [PW-1:0] back_first;

    assign line9    = {1'b0, line};
    assign in_range = newline && (line9 < NLINES);
    assign swap     = in_range && (line9 != front_line);
    assign replay   = in_range && (line9 == front_line);
    assign tgt_new  = (line == LLAST) ? 8'd0 : line + 8'd1;

    assign rd_inc      = rd + XW'(1);
    assign front_next  = fsel ? buf1[rd_inc] : buf0[rd_inc];
    assign front_first = fsel ? buf1[0] : buf0[0];
    assign back_first  = fsel ? buf0[0] : buf1[0];

    assign mem_req = (state == REQ);

    // Fetch FSM state register and fill bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            x        <= '0;
            mem_addr <= '0;
            drain    <= 1'b0;
            rstart   <= '0;
            underrun <= 1'b0;
        end else begin
            state    <= state_n;
            x        <= x_n;
            mem_addr <= addr_n;
            drain    <= drain_n;
            rstart   <= rstart_n;
            underrun <= ur_n;
        end
    end

    // Fetch next-state: fill the back buffer, restart or abort on a swap.
    always_comb begin
        state_n   = state;
        x_n       = x;
        addr_n    = mem_addr;
        drain_n   = drain;
        rstart_n  = rstart;
        ur_n      = 1'b0;
        wr_en     = 1'b0;
        fill_done = 1'b0;

        unique case (state)
            IDLE: begin
                state_n = REQ;
                addr_n  = start_addr(8'd0);
                x_n     = '0;
            end
            REQ: begin
                if (mem_ack) begin
                    if (drain) begin
                        drain_n = 1'b0;
                        addr_n  = rstart;
                        x_n     = '0;
                    end else begin
                        wr_en = 1'b1;
                        if (x == XLAST) begin
                            state_n   = DONE;
                            fill_done = 1'b1;
                        end else begin
                            x_n    = x + XW'(1);
                            addr_n = mem_addr + AW'(1);
                        end
                    end
                end
            end
            DONE: begin
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (swap) begin
            if (state == DONE || fill_done) begin
                state_n = REQ;
                addr_n  = start_addr(tgt_new);
                x_n     = '0;
                drain_n = 1'b0;
            end else begin
                ur_n = 1'b1;
                if (state == REQ && !mem_ack) begin
                    // the in-flight request must still be acked; drop its data
                    drain_n  = 1'b1;
                    rstart_n = start_addr(tgt_new);
                end else begin
                    state_n = REQ;
                    addr_n  = start_addr(tgt_new);
                    x_n     = '0;
                    drain_n = 1'b0;
                end
            end
        end
    end

    // Back-buffer write port; contents are not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (fsel) begin
                buf0[x] <= mem_rdata;
            end else begin
                buf1[x] <= mem_rdata;
            end
        end
    end

    // Display side: buffer swap, replay and doubled pixel stepping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsel       <= 1'b0;
            front_line <= NLINES;
            rd         <= '0;
            sub        <= '0;
            pixel      <= '0;
        end else if (swap) begin
            fsel       <= ~fsel;
            front_line <= line9;
            rd         <= '0;
            sub        <= '0;
            pixel      <= back_first;
        end else if (replay) begin
            rd    <= '0;
            sub   <= '0;
            pixel <= front_first;
        end else if (advance) begin
            if (sub == SLAST) begin
                sub <= '0;
                if (rd != XLAST) begin
                    rd    <= rd_inc;
                    pixel <= front_next;
                end
            end else begin
                sub <= sub + SW'(1);
            end
        end
    end

endmodule

// File: tb/tb_vga_line_fetch.sv
// tb_vga_line_fetch: randomized bench for vga_line_fetch against a
// scanline-level model of buffers, fetch jobs and doubled pixels.
module tb_vga_line_fetch;

    localparam int BPP   = 4;
    localparam int WIDTH = 320;
    localparam int LINES = 240;
    localparam int HD    = 2;
    localparam int AW    = 17;
    localparam int BASE  = 0;
    localparam int PW    = 3 * BPP;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          newline = 1'b0;
    logic          advance = 1'b0;
    logic [7:0]    line = 8'd0;
    logic [PW-1:0] pixel;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [PW-1:0] mem_rdata;
    logic          underrun;
    logic          gate = 1'b0;

    assign mem_ack   = mem_req & gate;
    assign mem_rdata = mem_addr[PW-1:0];

    vga_line_fetch #(
        .BPP(BPP), .WIDTH(WIDTH), .LINES(LINES),
        .HDOUBLE(HD), .AW(AW), .BASE(BASE)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .newline(newline),
        .advance(advance),
        .line(line),
        .pixel(pixel),
        .mem_req(mem_req),
        .mem_addr(mem_addr),
        .mem_ack(mem_ack),
        .mem_rdata(mem_rdata),
        .underrun(underrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ack_pct = 100;
    bit hold = 1'b0;
    int acks = 0;

    // model state
    int bufm [2][WIDTH];
    int fi, fl, adv_cnt, exp_pix, exp_addr;
    bit exp_req, exp_ur;
    bit started, active, discard;
    int jt, jn, ptgt;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    function automatic int fb(input int t, input int n);
        return (BASE + t * WIDTH + n) % (1 << AW);
    endfunction

    function automatic int pidx(input int c);
        int i;
        i = c / HD;
        return (i > WIDTH - 1) ? WIDTH - 1 : i;
    endfunction

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < WIDTH; i++)
                bufm[b][i] = -1;
        fi = 0; fl = LINES; adv_cnt = 0;
        exp_pix = 0; exp_addr = 0;
        exp_req = 0; exp_ur = 0;
        started = 0; active = 0; discard = 0;
        jt = 0; jn = 0; ptgt = 0;
    endtask

    // One clock edge of the reference: what the scanline and fetch job
    // look like after the edge, given this cycle's inputs and ack.
    task automatic model_edge(input bit nl, input int ln,
                              input bit adv, input bit ack);
        bit sw, rp, was, do_w;
        int wb, wn, wv, nt, o, n;
        wb = 0; wn = 0; wv = 0;
        sw = nl && ln < LINES && ln != fl;
        rp = nl && ln < LINES && ln == fl;
        if (sw) exp_pix = bufm[1 - fi][0];
        else if (rp) exp_pix = bufm[fi][0];
        else if (adv) begin
            o = pidx(adv_cnt);
            adv_cnt++;
            n = pidx(adv_cnt);
            if (n != o) exp_pix = bufm[fi][n];
        end
        if (sw || rp) adv_cnt = 0;
        was = started;
        started = 1;
        do_w = 0;
        exp_ur = 0;
        if (ack) begin
            if (discard) begin
                discard = 0; jt = ptgt; jn = 0;
            end else begin
                do_w = 1; wb = 1 - fi; wn = jn;
                wv = fb(jt, jn) % (1 << PW);
                jn++;
                if (jn == WIDTH) active = 0;
            end
        end
        if (!was && !sw) begin
            active = 1; jt = 0; jn = 0;
        end
        if (sw) begin
            nt = (ln == LINES - 1) ? 0 : ln + 1;
            if (!was || active) exp_ur = 1;
            if (was && active && !ack) begin
                discard = 1; ptgt = nt;
            end else begin
                active = 1; discard = 0; jt = nt; jn = 0;
            end
            fi = 1 - fi;
            fl = ln;
        end
        if (do_w) bufm[wb][wn] = wv;
        exp_req = active;
        if (active && !discard) exp_addr = fb(jt, jn);
    endtask

    task automatic cycle(input bit nl, input int ln, input bit adv);
        bit g;
        newline = nl;
        line = 8'(ln);
        advance = adv;
        g = (int'($urandom_range(99)) < ack_pct) && !hold;
        gate = g;
        model_edge(nl, ln, adv, exp_req && g);
        #1;
        if (mem_ack) acks++;
        @(posedge clk);
        @(negedge clk);
        check("req", int'(mem_req), int'(exp_req));
        check("urun", int'(underrun), int'(exp_ur));
        if (exp_req) check("addr", int'(mem_addr), exp_addr);
        if (exp_pix >= 0) check("pix", int'(pixel), exp_pix);
    endtask

    task automatic run_until_done(input int bound);
        for (int i = 0; i < bound; i++) begin
            if (!exp_req) break;
            cycle(0, 0, 0);
        end
        check("fetch_done", int'(mem_req), 0);
    endtask

    initial begin
        int urc;
        int pv;
        #1 rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst0_pix", int'(pixel), 0);
        check("rst0_req", int'(mem_req), 0);
        check("rst0_addr", int'(mem_addr), 0);
        check("rst0_urun", int'(underrun), 0);
        rst_n = 1'b1;

        // initial fill of line 0 at zero wait
        ack_pct = 100; hold = 0; acks = 0;
        cycle(0, 0, 0);
        check("first_req", int'(mem_req), 1);
        check("first_addr", int'(mem_addr), 0);
        run_until_done(400);
        check("acks_l0", acks, WIDTH);

        // display line 0, prefetch line 1
        cycle(1, 0, 0);
        check("l1_addr", int'(mem_addr), WIDTH);
        for (int i = 0; i < 2 * WIDTH; i++) begin
            check("seq_first", int'(pixel), i / 2);
            cycle(0, 0, 1);
        end
        repeat (4) cycle(0, 0, 1);
        check("sat_pix", int'(pixel), WIDTH - 1);
        run_until_done(20);

        // doubled scanline: replay without refetch
        cycle(1, 0, 0);
        check("no_refetch", int'(mem_req), 0);
        for (int i = 0; i < 2 * WIDTH; i++) begin
            check("seq_replay", int'(pixel), i / 2);
            cycle(0, 0, 1);
        end

        // last line wraps the prefetch to line 0
        cycle(1, LINES - 1, 0);
        check("wrap_req", int'(mem_req), 1);
        check("wrap_addr", int'(mem_addr), 0);
        run_until_done(400);
        pv = exp_pix;
        for (int l = LINES; l < 256; l++) begin
            cycle(1, l, 0);
            check("blank_pix", int'(pixel), pv);
            check("blank_req", int'(mem_req), 0);
        end

        // reset in the middle of a fetch
        cycle(1, 0, 0);
        repeat (50) cycle(0, 0, 1);
        newline = 0; advance = 0; gate = 0;
        rst_n = 1'b0;
        #1;
        check("rst_pix", int'(pixel), 0);
        check("rst_req", int'(mem_req), 0);
        check("rst_addr", int'(mem_addr), 0);
        check("rst_urun", int'(underrun), 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cycle(0, 0, 0);
        check("rst_restart", int'(mem_addr), 0);
        run_until_done(400);

        // memory stalls across a swap
        hold = 1;
        cycle(1, 0, 0);
        repeat (200) cycle(0, 0, 1);
        cycle(1, 1, 0);
        urc = int'(underrun);
        check("urun_pulse", int'(underrun), 1);
        check("drain_addr", int'(mem_addr), WIDTH);
        repeat (3) begin
            cycle(0, 0, 1);
            urc += int'(underrun);
        end
        check("urun_once", urc, 1);
        hold = 0; ack_pct = 100;
        cycle(0, 0, 1);
        check("restart_l2", int'(mem_addr), 2 * WIDTH);
        ack_pct = 60;
        run_until_done(2000);

        // random scanline traffic and memory latency
        for (int s = 0; s < 40; s++) begin
            int r, ln, na;
            r = int'($urandom_range(9));
            if (r < 6) ln = (fl >= LINES - 1) ? 0 : fl + 1;
            else if (r < 8) ln = fl;
            else if (r == 8) ln = int'($urandom_range(255, LINES));
            else ln = int'($urandom_range(LINES - 1));
            ack_pct = int'($urandom_range(100, 30));
            cycle(1, ln, bit'($urandom_range(1)));
            repeat ($urandom_range(20)) cycle(0, 0, 0);
            na = int'($urandom_range(700, 600));
            repeat (na) cycle(0, 0, 1);
            repeat ($urandom_range(10)) cycle(0, 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_line_fetch.md
Name: vga_line_fetch

Overview:
- Pixel source for the VGA timing generator; sits on the other end of its newline/advance/line/pixel request interface.
- Holds two ping-pong line buffers: one feeds pixels to the timing generator, the other is filled from a word-per-pixel framebuffer memory.
- Prefetches source line L+1 while line L is displayed.
- Doubles pixels horizontally (320 source pixels over 640 advances); line doubling arrives from the timing generator's repeated line index.

Parameters:
- BPP, 4, bits per colour channel; pixel word is 3*BPP (R high, G mid, B low).
- WIDTH, 320, source pixels per line.
- LINES, 240, source lines per frame; line indices >= LINES denote blanking.
- HDOUBLE, 2, advance cycles per source pixel (1 or 2).
- AW, 17, framebuffer address width.
- BASE, 0, framebuffer start address.

Ports:
- clk  in  1  pixel clock (25 MHz), sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- newline  in  1  one-cycle pulse at start of each scanline.
- advance  in  1  high for each active pixel cycle.
- line  in  8  source line index for the scanline announced by newline.
- pixel  out  3*BPP  current pixel; must be valid in every cycle advance is high.
- mem_req  out  1  read request.
- mem_addr  out  AW  read address, stable while mem_req high.
- mem_ack  in  1  request accepted; mem_rdata valid in the same cycle.
- mem_rdata  in  3*BPP  read data.
- underrun  out  1  one-cycle pulse when a swap or restart hits an incomplete fetch.

Behaviour:
- Reset (async assert, sync release):
  - pixel=0, mem_req=0, mem_addr=0, underrun=0.
  - front buffer marked invalid; front_line=LINES (no line displayed).
  - First cycle after release: fetch FSM starts filling the back buffer with line 0.
- Fetch FSM states: IDLE, REQ, DONE.
  - REQ: mem_req=1, mem_addr = BASE + tgt*WIDTH + x, computed mod 2^AW.
  - On mem_ack: write mem_rdata to back[x] and increment x.
  - Ack with x==WIDTH-1 -> DONE (mem_req drops the next cycle).
  - mem_req is never withdrawn before its ack.
- newline with line >= LINES: ignored; no swap, no fetch, pointers unchanged.
- newline with line == front_line: replay; read pointer and subpixel counter cleared, pixel loaded with front[0].
- newline with line L != front_line and L < LINES:
  - Swap buffers; front_line=L; pixel loaded with new front[0].
  - Start fetch of tgt = (L==LINES-1) ? 0 : L+1 into the new back buffer.
  - If the FSM was not in DONE at the swap: underrun pulses the next cycle.
  - Underrun abort: if a request is outstanding, wait for its ack, discard the data, then restart at x=0 for the new tgt.
  - The front buffer then holds partial data; its unwritten entries keep stale contents.
- Pixel output:
  - pixel is registered and equals front[rd] from the cycle after newline.
  - Each advance cycle increments subpixel counter s. When s==HDOUBLE-1: s<=0, rd<=rd+1, pixel<=front[rd+1] for the next cycle.
  - rd saturates at WIDTH-1; extra advances repeat the last pixel.
  - While advance is low, pixel holds its value. The timing generator blanks outside active, so no zeroing is needed here.
- Simultaneous events:
  - newline and advance in the same cycle: newline wins.
  - newline in the same cycle as the final ack: the fetch counts as complete, no underrun.
- Wrap: line LINES-1 prefetches line 0, so the next frame's first line is ready before its newline.
- Throughput: at one ack per cycle a 320-pixel fetch takes about 321 cycles, within the 1600-cycle doubled line period.

Test Plan:
- Reset, framebuffer mem[a]=a[11:0], zero-wait ack -> mem_addr runs 0..319 with 320 acks, FSM reaches DONE, underrun stays 0.
- newline with line=0, then 640 advances -> pixel shows 0,0,1,1,...,319,319; fetch addresses 320..639 start next cycle.
- Second newline with line=0 (doubled scanline) -> no swap, no new fetch, pixel sequence identical to the first scanline.
- newline line=1 when mem_ack is held low for 200 cycles -> swap occurs, underrun pulses exactly one cycle, then fetch of line 2 restarts at address 640.
- newline line=239 -> fetch addresses 0..319 (line 0 wrap); then newlines with line=240..255 -> no activity, pixel unchanged.
- Assert rst_n low mid-fetch with mem_req high -> outputs 0 immediately; after release the fetch restarts at address 0.
